// File: rtl/alu_dmem_unit.sv
// alu_dmem_unit: RV32I execute/memory stage - ALU, byte-addressed data memory, load formatter.
// Memory is little-endian, index = ALUOut mod DEPTH, multi-byte accesses wrap.
module alu_dmem_unit #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] DataA,
    input  logic [31:0] DataB,
    input  logic [3:0]  ALUSel,
    input  logic [31:0] DataW,
    input  logic        MemRW,
    input  logic [1:0]  LenSel,
    input  logic [2:0]  FormatSel,
    output logic [31:0] ALUOut,
    output logic [31:0] DataROut
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] a0, a1, a2, a3;
    logic [31:0]   data_r;
    logic [4:0]    sh;

    assign sh = DataB[4:0];

    always_comb begin
        ALUOut = '0;
        case (ALUSel)
            4'b0000: ALUOut = DataA + DataB;
            4'b0001: ALUOut = DataA - DataB;
            4'b0010: ALUOut = DataA << sh;
            4'b0011: ALUOut = {31'b0, $signed(DataA) < $signed(DataB)};
            4'b0100: ALUOut = {31'b0, DataA < DataB};
            4'b0101: ALUOut = DataA ^ DataB;
            4'b0110: ALUOut = DataA >> sh;
            4'b0111: ALUOut = $unsigned($signed(DataA) >>> sh);
            4'b1000: ALUOut = DataA | DataB;
            4'b1001: ALUOut = DataA & DataB;
            4'b1010: ALUOut = DataB;
            default: ALUOut = '0;
        endcase
    end

    // AW-bit index arithmetic gives the DEPTH-1 -> 0 wrap for free
    assign a0 = ALUOut[AW-1:0];
    assign a1 = a0 + AW'(1);
    assign a2 = a0 + AW'(2);
    assign a3 = a0 + AW'(3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (MemRW) begin
            mem[a0] <= DataW[7:0];
            if (LenSel != 2'b00) mem[a1] <= DataW[15:8];
            if (LenSel[1]) begin
                mem[a2] <= DataW[23:16];
                mem[a3] <= DataW[31:24];
            end
        end
    end

    assign data_r = {mem[a3], mem[a2], mem[a1], mem[a0]};

    always_comb begin
        DataROut = data_r;
        case (FormatSel)
            3'b000:  DataROut = {{24{data_r[7]}}, data_r[7:0]};
            3'b001:  DataROut = {{16{data_r[15]}}, data_r[15:0]};
            3'b011:  DataROut = {24'b0, data_r[7:0]};
            3'b100:  DataROut = {16'b0, data_r[15:0]};
            default: DataROut = data_r;
        endcase
    end
endmodule

// File: tb/tb_alu_dmem_unit.sv
// tb_alu_dmem_unit: directed plus random stimulus against a byte-array reference model.
module tb_alu_dmem_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] DataA = '0, DataB = '0, DataW = '0;
    logic [3:0]  ALUSel = '0;
    logic        MemRW = 1'b0;
    logic [1:0]  LenSel = '0;
    logic [2:0]  FormatSel = '0;
    logic [31:0] ALUOut, DataROut;

    int checks = 0;
    int errors = 0;
    logic [7:0] ref_mem [1024];

    alu_dmem_unit #(.DEPTH(1024)) dut (
        .clk(clk), .rst_n(rst_n), .DataA(DataA), .DataB(DataB), .ALUSel(ALUSel),
        .DataW(DataW), .MemRW(MemRW), .LenSel(LenSel), .FormatSel(FormatSel),
        .ALUOut(ALUOut), .DataROut(DataROut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
        int unsigned n = b % 32;
        case (s)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a << n;
            4'd3:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd4:  return (a < b) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return a >> n;
            4'd7:  return (a >> n) | (a[31] ? ~(32'hFFFF_FFFF >> n) : 32'd0);
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f);
        int unsigned i = addr % 1024;
        logic [31:0] r = 0;
        for (int k = 3; k >= 0; k--) r = (r << 8) | 32'(ref_mem[(i + k) % 1024]);
        case (f)
            3'd0: return (r & 32'hFF) - (r[7] ? 32'd256 : 32'd0);
            3'd1: return (r & 32'hFFFF) - (r[15] ? 32'd65536 : 32'd0);
            3'd3: return r & 32'hFF;
            3'd4: return r & 32'hFFFF;
            default: return r;
        endcase
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] w);
        int unsigned i = addr % 1024;
        int n = (len == 0) ? 1 : (len == 1) ? 2 : 4;
        for (int k = 0; k < n; k++) ref_mem[(i + k) % 1024] = 8'(w >> (8 * k));
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s, input logic [31:0] w,
                       input logic rw, input logic [1:0] len, input logic [2:0] f, input string tag);
        logic [31:0] addr = ref_alu(a, b, s);
        @(negedge clk);
        DataA = a; DataB = b; ALUSel = s; DataW = w; MemRW = rw; LenSel = len; FormatSel = f;
        #1;
        check({tag, "/alu"}, ALUOut, addr);
        check({tag, "/ld"}, DataROut, ref_load(addr, f));
        if (rw && rst_n) begin
            @(posedge clk);
            ref_store(addr, len, w);
        end
    endtask

    task automatic ld(input logic [31:0] addr, input logic [2:0] f, input logic [31:0] exp, input string tag);
        run(addr, 0, 4'd0, 0, 1'b0, 2'd0, f, tag);
        check({tag, "/const"}, DataROut, exp);
    endtask

    task automatic st(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] w, input string tag);
        run(addr, 0, 4'd0, w, 1'b1, len, 3'd2, tag);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        DataA = 32'h0000_0010; DataB = 32'h5; ALUSel = 4'd0; FormatSel = 3'd0;
        #1;
        check("rst_alu", ALUOut, 32'h15);
        check("rst_lb", DataROut, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run(32'hFFFF_FFFF, 32'd1, 4'd0, 0, 0, 0, 2, "add_wrap");
        check("add_wrap_c", ALUOut, 32'h0);
        run(32'd0, 32'd1, 4'd1, 0, 0, 0, 2, "sub_wrap");
        check("sub_wrap_c", ALUOut, 32'hFFFF_FFFF);
        run(32'hFFFF_FFFF, 32'd1, 4'd3, 0, 0, 0, 2, "slt");
        check("slt_c", ALUOut, 32'd1);
        run(32'hFFFF_FFFF, 32'd1, 4'd4, 0, 0, 0, 2, "sltu");
        check("sltu_c", ALUOut, 32'd0);
        run(32'h8000_0000, 32'h21, 4'd7, 0, 0, 0, 2, "sra");
        check("sra_c", ALUOut, 32'hC000_0000);
        run(32'h8000_0000, 32'h21, 4'd6, 0, 0, 0, 2, "srl");
        check("srl_c", ALUOut, 32'h4000_0000);
        run(32'h8000_0000, 32'h21, 4'd2, 0, 0, 0, 2, "sll");
        check("sll_c", ALUOut, 32'h0);
        run(32'h1234_5678, 32'h9ABC_DEF0, 4'd15, 0, 0, 0, 2, "nop");
        check("nop_c", ALUOut, 32'h0);

        st(32'h10, 2'd2, 32'hDEAD_BEEF, "sw10");
        ld(32'h10, 3'd2, 32'hDEAD_BEEF, "lw10");
        ld(32'h10, 3'd0, 32'hFFFF_FFEF, "lb10");
        ld(32'h13, 3'd3, 32'h0000_00DE, "lbu13");
        ld(32'h12, 3'd4, 32'h0000_DEAD, "lhu12");
        st(32'h11, 2'd0, 32'h1234_5677, "sb11");
        ld(32'h10, 3'd2, 32'hDEAD_77EF, "lw10_sb");
        st(32'h12, 2'd1, 32'h0000_ABCD, "sh12");
        ld(32'h10, 3'd2, 32'hABCD_77EF, "lw10_sh");
        ld(32'h12, 3'd1, 32'hFFFF_ABCD, "lh12");

        st(32'h3FE, 2'd3, 32'h1122_3344, "sw3fe");
        ld(32'h3FE, 3'd3, 32'h44, "lbu3fe");
        ld(32'h001, 3'd3, 32'h11, "lbu001");
        ld(32'h3FE, 3'd2, 32'h1122_3344, "lw3fe");
        ld(32'h400, 3'd4, 32'h1122, "lhu400");
        ld(32'hFFFF_F3FE, 3'd2, 32'h1122_3344, "lw_hi_ignored");

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, b, w;
            logic [3:0] s;
            w = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom; b = $urandom; s = 4'($urandom_range(0, 15));
                run(a, b, s, w, 1'b0, 2'($urandom), 3'($urandom_range(0, 7)), "rnd_alu");
            end else begin
                a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 47));
                b = 32'($urandom_range(0, 7));
                run(a, b, 4'd0, w, 1'($urandom), 2'($urandom), 3'($urandom_range(0, 7)), "rnd_mem");
            end
        end

        st(32'h20, 2'd2, 32'hCAFE_F00D, "sw20");
        @(negedge clk);
        MemRW = 1'b0; DataA = 32'h20; DataB = 0; ALUSel = 4'd0; FormatSel = 3'd2;
        #2;
        check("pre_rst", DataROut, 32'hCAFE_F00D);
        rst_n = 1'b0;
        #1;
        check("rst_mid", DataROut, 32'h0);
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        run(32'h40, 0, 4'd0, 32'h5555_AAAA, 1'b1, 2'd2, 3'd2, "wr_in_rst");
        @(posedge clk);
        #1;
        check("wr_in_rst_held", DataROut, 32'h0);
        @(negedge clk);
        MemRW = 1'b0;
        rst_n = 1'b1;
        ld(32'h40, 3'd2, 32'h0, "after_rst40");
        ld(32'h10, 3'd2, 32'h0, "after_rst10");
        st(32'h40, 2'd2, 32'h0BAD_BEEF, "sw_post");
        ld(32'h40, 3'd2, 32'h0BAD_BEEF, "lw_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
